// File: rtl/alu_issue_pkg.sv
// rtl/alu_issue_pkg.sv - shared opcodes, instruction field positions and widths for the ALU issue stage
package alu_issue_pkg;

  localparam int DATA_W  = 32;
  localparam int N_REGS  = 32;
  localparam int REG_W   = 5;
  localparam int STALL_W = 16;
  localparam int INSTR_W = 32;

  localparam int OPC_HI  = 31;
  localparam int OPC_LO  = 27;
  localparam int RD_HI   = 26;
  localparam int RD_LO   = 22;
  localparam int RS_HI   = 21;
  localparam int RS_LO   = 17;
  localparam int IMM_SEL = 16;
  localparam int RT_HI   = 15;
  localparam int RT_LO   = 11;
  localparam int IMM_HI  = 15;
  localparam int IMM_LO  = 0;

  typedef enum logic [4:0] {
    OP_ADD = 5'd0,
    OP_SUB = 5'd1,
    OP_MPY = 5'd2,
    OP_AND = 5'd3,
    OP_OR  = 5'd4,
    OP_XOR = 5'd5,
    OP_SHL = 5'd6,
    OP_SRA = 5'd7,
    OP_SRL = 5'd8,
    OP_MOV = 5'd9
  } opcode_e;

  // Legal opcodes are contiguous from zero, so one compare covers the set.
  function automatic logic is_legal(input logic [4:0] op);
    return op <= OP_MOV;
  endfunction

endpackage

// File: rtl/alu_scoreboard.sv
// rtl/alu_scoreboard.sv - pending-destination bits with set-wins update and hazard lookups
module alu_scoreboard
  import alu_issue_pkg::*;
#(
  parameter int NREGS = N_REGS
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_set_en,
  input  logic [REG_W-1:0] i_set_addr,
  input  logic             i_clr_en,
  input  logic [REG_W-1:0] i_clr_addr,
  input  logic [REG_W-1:0] i_q_rs,
  input  logic [REG_W-1:0] i_q_rt,
  input  logic [REG_W-1:0] i_q_rd,
  output logic             o_busy_rs,
  output logic             o_busy_rt,
  output logic             o_busy_rd,
  output logic [NREGS-1:0] o_pending
);

  logic [NREGS-1:0] r_pending;
  logic [NREGS-1:0] w_set_mask;
  logic [NREGS-1:0] w_clr_mask;

  always_comb begin
    w_set_mask = '0;
    w_clr_mask = '0;
    if (i_set_en) w_set_mask[i_set_addr] = 1'b1;
    if (i_clr_en) w_clr_mask[i_clr_addr] = 1'b1;
  end

  // Set is OR-ed after the clear so a same-cycle issue to a retiring register stays pending.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_pending <= '0;
    else          r_pending <= (r_pending & ~w_clr_mask) | w_set_mask;
  end

  // A writeback landing this cycle resolves the lookup for its register.
  assign o_busy_rs = r_pending[i_q_rs] && !(i_clr_en && (i_clr_addr == i_q_rs));
  assign o_busy_rt = r_pending[i_q_rt] && !(i_clr_en && (i_clr_addr == i_q_rt));
  assign o_busy_rd = r_pending[i_q_rd] && !(i_clr_en && (i_clr_addr == i_q_rd));
  assign o_pending = r_pending;

endmodule

// File: rtl/alu_issue.sv
// rtl/alu_issue.sv - decode/issue stage: decode, register read with bypass, hazard stall, registered ALU bundle
module alu_issue
  import alu_issue_pkg::*;
#(
  parameter int WIDTH  = DATA_W,
  parameter int NREGS  = N_REGS,
  parameter int STALLW = STALL_W
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_in_valid,
  output logic               o_in_ready,
  input  logic [INSTR_W-1:0] i_in_instr,
  output logic [REG_W-1:0]   o_rf_raddr_a,
  output logic [REG_W-1:0]   o_rf_raddr_b,
  input  logic [WIDTH-1:0]   i_rf_rdata_a,
  input  logic [WIDTH-1:0]   i_rf_rdata_b,
  input  logic               i_wb_valid,
  input  logic [REG_W-1:0]   i_wb_addr,
  input  logic [WIDTH-1:0]   i_wb_data,
  output logic               o_out_valid,
  input  logic               i_out_ready,
  output logic [4:0]         o_out_opcode,
  output logic [WIDTH-1:0]   o_out_data_a,
  output logic [WIDTH-1:0]   o_out_data_b,
  output logic [REG_W-1:0]   o_out_rd,
  output logic               o_illegal_op,
  output logic [STALLW-1:0]  o_stall_count
);

  logic [4:0]        w_opcode;
  logic [REG_W-1:0]  w_rd, w_rs, w_rt;
  logic              w_imm_sel;
  logic [15:0]       w_imm;
  logic              w_legal, w_uses_rt;
  logic              w_busy_rs, w_busy_rt, w_busy_rd, w_hazard;
  logic              w_take, w_accept, w_drop;
  logic [WIDTH-1:0]  w_opnd_a, w_byp_b, w_opnd_b;
  logic [NREGS-1:0]  w_pending;

  logic              r_out_valid;
  logic [4:0]        r_out_opcode;
  logic [WIDTH-1:0]  r_out_data_a, r_out_data_b;
  logic [REG_W-1:0]  r_out_rd;
  logic              r_illegal_op;
  logic [STALLW-1:0] r_stall_count;

  assign w_opcode  = i_in_instr[OPC_HI:OPC_LO];
  assign w_rd      = i_in_instr[RD_HI:RD_LO];
  assign w_rs      = i_in_instr[RS_HI:RS_LO];
  assign w_rt      = i_in_instr[RT_HI:RT_LO];
  assign w_imm_sel = i_in_instr[IMM_SEL];
  assign w_imm     = i_in_instr[IMM_HI:IMM_LO];

  assign w_legal   = is_legal(w_opcode);
  assign w_uses_rt = !w_imm_sel && (w_opcode != OP_MOV);

  assign o_rf_raddr_a = w_rs;
  assign o_rf_raddr_b = w_rt;

  alu_scoreboard #(.NREGS(NREGS)) u_sb (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_set_en   (w_accept),
    .i_set_addr (w_rd),
    .i_clr_en   (i_wb_valid),
    .i_clr_addr (i_wb_addr),
    .i_q_rs     (w_rs),
    .i_q_rt     (w_rt),
    .i_q_rd     (w_rd),
    .o_busy_rs  (w_busy_rs),
    .o_busy_rt  (w_busy_rt),
    .o_busy_rd  (w_busy_rd),
    .o_pending  (w_pending)
  );

  // Hazard is left ungated by in_valid so ready depends only on the instruction and downstream.
  assign w_hazard   = w_busy_rs || (w_uses_rt && w_busy_rt) || w_busy_rd;
  assign o_in_ready = (!r_out_valid || i_out_ready) && !w_hazard;
  assign w_take     = i_in_valid && o_in_ready;
  assign w_accept   = w_take && w_legal;
  assign w_drop     = w_take && !w_legal;

  assign w_opnd_a = (i_wb_valid && (i_wb_addr == w_rs)) ? i_wb_data : i_rf_rdata_a;
  assign w_byp_b  = (i_wb_valid && (i_wb_addr == w_rt)) ? i_wb_data : i_rf_rdata_b;
  assign w_opnd_b = w_imm_sel ? {{(WIDTH-16){w_imm[15]}}, w_imm} : w_byp_b;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_out_valid  <= 1'b0;
      r_out_opcode <= '0;
      r_out_data_a <= '0;
      r_out_data_b <= '0;
      r_out_rd     <= '0;
    end else if (w_accept) begin
      r_out_valid  <= 1'b1;
      r_out_opcode <= w_opcode;
      r_out_data_a <= w_opnd_a;
      r_out_data_b <= w_opnd_b;
      r_out_rd     <= w_rd;
    end else if (i_out_ready) begin
      r_out_valid  <= 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_illegal_op  <= 1'b0;
      r_stall_count <= '0;
    end else begin
      r_illegal_op <= w_drop;
      if (i_in_valid && w_hazard && (r_stall_count != {STALLW{1'b1}}))
        r_stall_count <= r_stall_count + 1'b1;
    end
  end

  assign o_out_valid   = r_out_valid;
  assign o_out_opcode  = r_out_opcode;
  assign o_out_data_a  = r_out_data_a;
  assign o_out_data_b  = r_out_data_b;
  assign o_out_rd      = r_out_rd;
  assign o_illegal_op  = r_illegal_op;
  assign o_stall_count = r_stall_count;

endmodule

// File: doc/alu_issue.md
Name: alu_issue

Overview:
- Decode/issue stage that drives the ALU's opcode and operand inputs.
- Accepts 32-bit instruction words over a valid/ready handshake and decodes the opcode, register and immediate fields.
- Reads the register file, tracks in-flight destinations with a scoreboard and stalls on hazards.
- Presents a registered {opcode, data_a, data_b, rd} bundle to the execute stage; writeback returns through a dedicated port that clears the scoreboard and bypasses data.

Parameters:
- WIDTH, 32, datapath width; must equal the ALU data width.
- NREGS, 32, number of architectural registers; register index width is log2(NREGS) = 5.
- STALLW, 16, width of the saturating stall counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  instruction word present.
- in_ready  out  1  stage accepts the instruction this cycle.
- in_instr  in  32  instruction word.
- rf_raddr_a  out  5  register file read address A (rs).
- rf_raddr_b  out  5  register file read address B (rt).
- rf_rdata_a  in  WIDTH  combinational read data A, same cycle.
- rf_rdata_b  in  WIDTH  combinational read data B, same cycle.
- wb_valid  in  1  writeback this cycle.
- wb_addr  in  5  writeback register.
- wb_data  in  WIDTH  writeback data.
- out_valid  out  1  issued operation valid.
- out_ready  in  1  execute stage accepts.
- out_opcode  out  5  ALU opcode.
- out_data_a  out  WIDTH  operand A.
- out_data_b  out  WIDTH  operand B.
- out_rd  out  5  destination register.
- illegal_op  out  1  one-cycle pulse on an undefined opcode.
- stall_count  out  STALLW  saturating count of hazard-stall cycles.

Behaviour:
- Instruction format:
  - opcode = [31:27], rd = [26:22], rs = [21:17], imm_sel = [16].
  - imm_sel = 0: rt = [15:11].
  - imm_sel = 1: B operand = [15:0] sign-extended to WIDTH.
- Legal opcodes come from the shared defines header: ADD, SUB, MPY, AND, OR, XOR, SHL, SRA, SRL, MOV.
  - MOV uses rs only; no rt read and no rt hazard check.
- Read addresses: rf_raddr_a = rs and rf_raddr_b = rt, driven combinationally from in_instr.
- Bypass: if wb_valid and wb_addr equals a source index, that operand takes wb_data instead of rf_rdata.
- Scoreboard: NREGS pending bits.
  - Set pending[rd] on accept.
  - Clear pending[wb_addr] on wb_valid.
  - If set and clear hit the same register in one cycle, set wins.
- Hazard, evaluated only while in_valid:
  - (pending[rs] && !(wb_valid && wb_addr == rs)), or
  - (uses rt && pending[rt] && !(wb_valid && wb_addr == rt)), or
  - (pending[rd] && !(wb_valid && wb_addr == rd)).
  - A match on the same-cycle writeback resolves the hazard.
- in_ready = (!out_valid || out_ready) && !hazard.
  - in_ready may depend on in_instr.
  - in_ready must not depend on in_valid or on any other input-side handshake signal.
- Accept occurs when in_valid && in_ready && the opcode is legal:
  - capture the out_* fields and set out_valid next cycle.
  - Latency from accept to out_valid is 1 cycle.
- Illegal opcode with in_valid && in_ready:
  - instruction consumed and dropped, illegal_op = 1 for one cycle.
  - Scoreboard and output register unchanged.
- Output hold: while out_valid && !out_ready, all out_* fields stay stable.
- Output release: out_valid clears after a handshake unless a new accept occurs in the same cycle (back-to-back issue allowed).
- stall_count: increments each cycle with in_valid && hazard, and saturates at all-ones.
- Reset (asynchronous, usable mid-operation) clears:
  - out_valid, all out_* fields, illegal_op, stall_count and every scoreboard bit, all to 0.
  - An in-flight output is discarded.

Decomposition:
- Shared defines header: opcode constants, the instruction field bit positions and WIDTH.
- One natural sub-module, alu_scoreboard: pending bit vector with set/clear ports, the set-wins rule and three hazard-query lookups with writeback bypass.

Test Plan:
- Reset, then ADD r3 = r1 + r2 with rf r1 = 5, r2 = 7, out_ready = 1 -> next cycle out_valid = 1, opcode ADD, data_a = 5, data_b = 7, rd = 3; pending[3] = 1.
- Dependent instruction SUB r4 = r3 - r1 while pending[3] = 1 and no writeback -> in_ready = 0 and stall_count increments each cycle. Then wb_valid with wb_addr = 3, wb_data = 12 -> accepted that cycle with data_a = 12.
- imm_sel = 1 with imm16 = 0xFFFE on XOR -> data_b = 0xFFFFFFFE.
- Opcode outside the legal set -> illegal_op pulses once, no out_valid, scoreboard unchanged.
- out_ready held 0 for 3 cycles with out_valid = 1 -> outputs stable and in_ready = 0. Then out_ready = 1 with in_valid -> back-to-back issue with no bubble.
- rst_n low while out_valid = 1 and pending bits set -> all outputs 0 and all scoreboard bits 0 immediately. Forced to 0xFFFF, stall_count holds at 0xFFFF through further stalls.
